// File: rtl/mulu_seq.sv
// Sequential shift-add multiplier: retires one multiplier bit per clock.
// Signed mode multiplies magnitudes and applies the sign at the end, so the
// datapath is purely unsigned. Handshake is valid/ready on both sides.
module mulu_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    c_q, c_d;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;

  // Next-state and datapath: accept latches magnitudes, BUSY adds one partial
  // product per cycle, the last iteration loads the signed-corrected result.
  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    addend  = mb_q[0] ? ({{WIDTH{1'b0}}, ma_q} << cnt_q) : '0;
    acc_sum = acc_q + addend;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_BUSY;
          ma_d    = (signed_mode & a[WIDTH-1]) ? -a : a;
          mb_d    = (signed_mode & b[WIDTH-1]) ? -b : b;
          neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        acc_d = acc_sum;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // Final iteration: the product is known this edge, so load c directly.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          c_d     = neg_q ? -acc_sum : acc_sum;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign c         = c_q;

endmodule

// File: tb/tb_mulu_seq.sv
// Bench for mulu_seq: directed cases on an 8-bit instance, randomised
// back-to-back traffic on 8- and 32-bit instances, scoreboard-checked.
module tb_mulu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail(input string nm);
    ntot++;
    $display("FAIL %s: timed out or unexpected event (t=%0t)", nm, $time);
  endtask

  // Reference: plain integer multiplication of the operands as the mode
  // interprets them, truncated to the product width.
  function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [63:0] r;
    if (s) begin
      sa = (w == 8) ? longint'($signed(a[7:0])) : longint'($signed(a));
      sb = (w == 8) ? longint'($signed(b[7:0])) : longint'($signed(b));
      r  = 64'(sa * sb);
    end else begin
      r = {32'b0, a} * {32'b0, b};
    end
    if (w == 8) r = r & 64'hFFFF;
    return r;
  endfunction

  // ---------------- 8-bit instance ----------------
  logic        rst8 = 1'b1, iv8 = 1'b0, s8 = 1'b0, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, bz8;
  logic [15:0] c8;

  mulu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(s8), .out_valid(ov8), .out_ready(or8), .c(c8), .busy(bz8)
  );

  // ---------------- 32-bit instance ----------------
  logic        rst32 = 1'b1, iv32 = 1'b0, s32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, bz32;
  logic [63:0] c32;

  mulu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .signed_mode(s32), .out_valid(ov32), .out_ready(or32), .c(c32), .busy(bz32)
  );

  // Scoreboards: expected products pushed on each accept, popped on each output.
  logic [63:0] q8[$];
  int          t8[$];
  logic [63:0] q32[$];
  int          t32[$];

  initial begin
    int last8 = -1;
    logic pov8 = 1'b0, por8 = 1'b0;
    logic [15:0] pc8 = '0;
    forever begin
      @(negedge clk);
      if (rst8) begin
        q8.delete(); t8.delete(); last8 = -1; pov8 = 1'b0; por8 = 1'b0;
      end else begin
        if (ov8 && !pov8) begin
          if (t8.size() == 0) fail("lat8_noop");
          else chk("lat8", 64'(cyc - t8[0]), 64'd8);
        end
        if (ov8 && pov8 && !por8) chk("hold8", {48'b0, c8}, {48'b0, pc8});
        if (ov8 && or8) begin
          if (q8.size() == 0) fail("dup8");
          else begin
            chk("c8", {48'b0, c8}, q8.pop_front());
            void'(t8.pop_front());
          end
        end
        if (iv8 && ir8) begin
          if (last8 >= 0) chk("ii8", 64'(cyc + 1 - last8 >= 10), 64'd1);
          q8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, s8));
          t8.push_back(cyc + 1);
          last8 = cyc + 1;
        end
        pov8 = ov8; por8 = or8; pc8 = c8;
      end
    end
  end

  initial begin
    int last32 = -1;
    logic pov32 = 1'b0, por32 = 1'b0;
    logic [63:0] pc32 = '0;
    forever begin
      @(negedge clk);
      if (rst32) begin
        q32.delete(); t32.delete(); last32 = -1; pov32 = 1'b0; por32 = 1'b0;
      end else begin
        if (ov32 && !pov32) begin
          if (t32.size() == 0) fail("lat32_noop");
          else chk("lat32", 64'(cyc - t32[0]), 64'd32);
        end
        if (ov32 && pov32 && !por32) chk("hold32", c32, pc32);
        if (ov32 && or32) begin
          if (q32.size() == 0) fail("dup32");
          else begin
            chk("c32", c32, q32.pop_front());
            void'(t32.pop_front());
          end
        end
        if (iv32 && ir32) begin
          if (last32 >= 0) chk("ii32", 64'(cyc + 1 - last32 >= 34), 64'd1);
          q32.push_back(model(32, a32, b32, s32));
          t32.push_back(cyc + 1);
          last32 = cyc + 1;
        end
        pov32 = ov32; por32 = or32; pc32 = c32;
      end
    end
  end

  // One directed operation on the 8-bit instance; checks the literal result.
  // Entered and left at one time unit after a rising edge.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input string nm);
    bit ok = 0;
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir8) begin ok = 1; break; end
    end
    if (!ok) begin fail({nm, "_accept"}); iv8 = 1'b0; return; end
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    @(negedge clk);
    chk({nm, "_busy"}, 64'(bz8), 64'd1);
    chk({nm, "_inrdy"}, 64'(ir8), 64'd0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (ov8) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin fail({nm, "_done"}); return; end
    chk(nm, {48'b0, c8}, {48'b0, exp});
    if (or8) begin
      @(negedge clk);
      chk({nm, "_ovdrop"}, 64'(ov8), 64'd0);
      chk({nm, "_ready"}, 64'(ir8), 64'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic random8(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      s8 = 1'($urandom); or8 = 1'($urandom);
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    for (int i = 0; i < 100 && (q8.size() != 0 || !ir8); i++) @(negedge clk);
    chk("drain8", 64'(q8.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic random32(input int ncyc);
    repeat (3) @(posedge clk);
    #1 rst32 = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      iv32 = 1'b1; a32 = $urandom; b32 = $urandom;
      s32 = 1'($urandom); or32 = 1'($urandom);
      // Bias some operands toward the extremes.
      if ($urandom_range(0, 7) == 0) a32 = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b32 = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0;
    end
    @(posedge clk); #1;
    iv32 = 1'b0; or32 = 1'b1;
    for (int i = 0; i < 200 && (q32.size() != 0 || !ir32); i++) @(negedge clk);
    chk("drain32", 64'(q32.size()), 64'd0);
  endtask

  task automatic directed8();
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inrdy", 64'(ir8), 64'd1);
    chk("rst_ov", 64'(ov8), 64'd0);
    chk("rst_busy", 64'(bz8), 64'd0);
    chk("rst_c", {48'b0, c8}, 64'd0);
    @(posedge clk); #1 rst8 = 1'b0; or8 = 1'b1;

    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "umax");
    run8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
    run8(8'h80, 8'h80, 1'b1, 16'h4000, "s_minmin");
    run8(8'h80, 8'h01, 1'b1, 16'hFF80, "s_minx1");
    run8(8'h80, 8'h80, 1'b0, 16'h4000, "u_80x80");
    run8(8'hFD, 8'h05, 1'b0, 16'h04F1, "u_fdx05");
    run8(8'h00, 8'hFF, 1'b1, 16'h0000, "s_zero");

    // Backpressure: result held while the consumer stalls.
    or8 = 1'b0;
    run8(8'h12, 8'h34, 1'b0, 16'h03A8, "bp");
    for (int i = 0; i < 20; i++) begin
      iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      @(negedge clk);
      chk("bp_ov", 64'(ov8), 64'd1);
      chk("bp_c", {48'b0, c8}, 64'h03A8);
      chk("bp_inrdy", 64'(ir8), 64'd0);
      @(posedge clk); #1;
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    chk("bp_ov_last", 64'(ov8), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_rdy", 64'(ir8), 64'd1);
    chk("bp_idle_ov", 64'(ov8), 64'd0);
    @(posedge clk); #1;

    // Reset mid-operation discards the in-flight product.
    a8 = 8'd200; b8 = 8'd200; s8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b1;
    @(posedge clk); #1 rst8 = 1'b0;
    @(negedge clk);
    chk("mrst_inrdy", 64'(ir8), 64'd1);
    chk("mrst_ov", 64'(ov8), 64'd0);
    chk("mrst_busy", 64'(bz8), 64'd0);
    chk("mrst_c", {48'b0, c8}, 64'd0);
    @(posedge clk); #1;
    run8(8'd7, 8'd9, 1'b0, 16'd63, "post_rst");

    random8(3000);
  endtask

  initial begin
    fork
      directed8();
      random32(3000);
    join
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  // Hard stop in case anything wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
